// File: rtl/controlador_lavadora_param.sv
// Coin-operated laundry controller: counts coins, evaluates the selected service
// on end-of-payment, runs it for a fixed time or flags a refund, then self-clears.
module controlador_lavadora_param #(
    parameter int WIDTH         = 5,
    parameter int PRECIO_SECADO = 3,
    parameter int PRECIO_LAVADO = 4,
    parameter int PRECIO_PESADO = 9,
    parameter int MAX_MONEDAS   = 15,
    parameter int DURACION      = 8,
    parameter int T_AVISO       = 4,
    parameter int T_ESPERA      = 32
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             INTRO_MONEDA,
    input  logic             FINALIZAR_PAGO,
    input  logic [1:0]       SELECCION,
    output logic             SECADO,
    output logic             LAVADO,
    output logic             LAVADO_PESADO,
    output logic             INSUFICIENTE,
    output logic [WIDTH-1:0] VUELTO,
    output logic [WIDTH-1:0] MONEDAS,
    output logic             RECHAZO,
    output logic             OCUPADO
);
    localparam int CMAX0 = (DURACION > T_AVISO) ? DURACION : T_AVISO;
    localparam int CMAX  = (CMAX0 > T_ESPERA) ? CMAX0 : T_ESPERA;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [WIDTH-1:0] P_SEC = WIDTH'(PRECIO_SECADO);
    localparam logic [WIDTH-1:0] P_LAV = WIDTH'(PRECIO_LAVADO);
    localparam logic [WIDTH-1:0] P_PES = WIDTH'(PRECIO_PESADO);
    localparam logic [WIDTH-1:0] M_MAX = WIDTH'(MAX_MONEDAS);

    typedef enum logic [1:0] {ESPERA, CONTANDO, SERVICIO, INSUF} estado_t;

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] monedas_q, monedas_d;
    logic [WIDTH-1:0] vuelto_q, vuelto_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             secado_q, secado_d;
    logic             lavado_q, lavado_d;
    logic             pesado_q, pesado_d;
    logic             insuf_q, insuf_d;
    logic             rechazo_q, rechazo_d;
    logic             ocupado_q, ocupado_d;
    logic             moneda_prev_q, fin_prev_q;

    logic             moneda_flanco, fin_flanco, sel_valida;
    logic [WIDTH-1:0] cuenta, precio;

    assign moneda_flanco = INTRO_MONEDA & ~moneda_prev_q;
    assign fin_flanco    = FINALIZAR_PAGO & ~fin_prev_q;
    assign sel_valida    = (SELECCION != 2'b11);

    // Count seen by the evaluation includes a coin landing in the same cycle.
    always_comb begin
        cuenta = monedas_q;
        if (moneda_flanco && monedas_q < M_MAX)
            cuenta = monedas_q + WIDTH'(1);
    end

    always_comb begin
        case (SELECCION)
            2'b00:   precio = P_SEC;
            2'b01:   precio = P_LAV;
            default: precio = P_PES;
        endcase
    end

    always_comb begin
        estado_d  = estado_q;
        monedas_d = monedas_q;
        vuelto_d  = vuelto_q;
        cnt_d     = cnt_q;
        secado_d  = secado_q;
        lavado_d  = lavado_q;
        pesado_d  = pesado_q;
        insuf_d   = insuf_q;
        ocupado_d = ocupado_q;
        rechazo_d = 1'b0;

        case (estado_q)
            ESPERA: begin
                if (moneda_flanco) begin
                    monedas_d = WIDTH'(1);
                    cnt_d     = '0;
                    estado_d  = CONTANDO;
                end
            end
            CONTANDO: begin
                cnt_d = moneda_flanco ? '0 : cnt_q + CW'(1);
                if (moneda_flanco && monedas_q == M_MAX)
                    rechazo_d = 1'b1;
                monedas_d = cuenta;
                if (fin_flanco) begin
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
                    if (sel_valida && cuenta >= precio) begin
                        estado_d = SERVICIO;
                        vuelto_d = cuenta - precio;
                        secado_d = (SELECCION == 2'b00);
                        lavado_d = (SELECCION == 2'b01);
                        pesado_d = (SELECCION == 2'b10);
                    end else begin
                        estado_d = INSUF;
                        vuelto_d = cuenta;
                        insuf_d  = 1'b1;
                    end
                end else if (!moneda_flanco && cnt_q == CW'(T_ESPERA - 1)) begin
                    estado_d  = INSUF;
                    vuelto_d  = monedas_q;
                    insuf_d   = 1'b1;
                    ocupado_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                // SERVICIO / INSUF: selection is latched, payment input ignored.
                rechazo_d = moneda_flanco;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == ((estado_q == SERVICIO) ? CW'(DURACION - 1) : CW'(T_AVISO - 1))) begin
                    estado_d  = ESPERA;
                    monedas_d = '0;
                    vuelto_d  = '0;
                    cnt_d     = '0;
                    secado_d  = 1'b0;
                    lavado_d  = 1'b0;
                    pesado_d  = 1'b0;
                    insuf_d   = 1'b0;
                    ocupado_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            estado_q      <= ESPERA;
            monedas_q     <= '0;
            vuelto_q      <= '0;
            cnt_q         <= '0;
            secado_q      <= 1'b0;
            lavado_q      <= 1'b0;
            pesado_q      <= 1'b0;
            insuf_q       <= 1'b0;
            rechazo_q     <= 1'b0;
            ocupado_q     <= 1'b0;
            moneda_prev_q <= 1'b0;
            fin_prev_q    <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            monedas_q     <= monedas_d;
            vuelto_q      <= vuelto_d;
            cnt_q         <= cnt_d;
            secado_q      <= secado_d;
            lavado_q      <= lavado_d;
            pesado_q      <= pesado_d;
            insuf_q       <= insuf_d;
            rechazo_q     <= rechazo_d;
            ocupado_q     <= ocupado_d;
            moneda_prev_q <= INTRO_MONEDA;
            fin_prev_q    <= FINALIZAR_PAGO;
        end
    end

    assign SECADO        = secado_q;
    assign LAVADO        = lavado_q;
    assign LAVADO_PESADO = pesado_q;
    assign INSUFICIENTE  = insuf_q;
    assign VUELTO        = vuelto_q;
    assign MONEDAS       = monedas_q;
    assign RECHAZO       = rechazo_q;
    assign OCUPADO       = ocupado_q;
endmodule

// File: tb/tb_controlador_lavadora_param.sv
// Directed bench for the laundry controller; inputs change and outputs are sampled on negedge.
module tb_controlador_lavadora_param;
    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       INTRO_MONEDA = 1'b0;
    logic       FINALIZAR_PAGO = 1'b0;
    logic [1:0] SELECCION = 2'b00;
    logic       SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE, RECHAZO, OCUPADO;
    logic [4:0] VUELTO, MONEDAS;

    int n_vec = 0;
    int n_err = 0;

    controlador_lavadora_param dut (
        .clk(clk), .RESET(RESET), .INTRO_MONEDA(INTRO_MONEDA),
        .FINALIZAR_PAGO(FINALIZAR_PAGO), .SELECCION(SELECCION),
        .SECADO(SECADO), .LAVADO(LAVADO), .LAVADO_PESADO(LAVADO_PESADO),
        .INSUFICIENTE(INSUFICIENTE), .VUELTO(VUELTO), .MONEDAS(MONEDAS),
        .RECHAZO(RECHAZO), .OCUPADO(OCUPADO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int flags();
        return {28'd0, SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE};
    endfunction

    task automatic coin(output logic rej);
        INTRO_MONEDA = 1'b1;
        tick();
        rej = RECHAZO;
        INTRO_MONEDA = 1'b0;
        tick();
    endtask

    task automatic coins(input int n);
        logic r;
        for (int i = 0; i < n; i++) coin(r);
    endtask

    task automatic finish(input logic [1:0] sel);
        SELECCION = sel;
        FINALIZAR_PAGO = 1'b1;
        tick();
        FINALIZAR_PAGO = 1'b0;
    endtask

    // Called in the first active cycle; checks the window length and the clear after it.
    task automatic chk_serv(input string tag, input int exp_flags, input int exp_vuelto, input int len);
        for (int i = 0; i < len; i++) begin
            chk({tag, ".flags"}, flags(), exp_flags);
            chk({tag, ".vuelto"}, VUELTO, exp_vuelto);
            chk({tag, ".ocupado"}, OCUPADO, 1);
            tick();
        end
        chk({tag, ".end_flags"}, flags(), 0);
        chk({tag, ".end_vuelto"}, VUELTO, 0);
        chk({tag, ".end_monedas"}, MONEDAS, 0);
        chk({tag, ".end_ocupado"}, OCUPADO, 0);
    endtask

    initial begin
        logic r;
        int   hi;

        tick(); tick();
        RESET = 1'b0;
        chk("reset.flags", flags(), 0);
        chk("reset.monedas", MONEDAS, 0);
        chk("reset.vuelto", VUELTO, 0);
        chk("reset.misc", {RECHAZO, OCUPADO}, 0);

        // Finish with no coins is ignored
        finish(2'b00);
        tick();
        chk("idle_fin.ocupado", OCUPADO, 0);
        chk("idle_fin.flags", flags(), 0);

        // 1: dry, exact payment
        coins(3);
        chk("t1.monedas", MONEDAS, 3);
        finish(2'b00);
        chk_serv("t1", 4'b1000, 0, 8);

        // 2: wash with change, heavy wash exact
        coins(5);
        finish(2'b01);
        chk_serv("t2a", 4'b0100, 1, 8);
        coins(9);
        finish(2'b10);
        chk_serv("t2b", 4'b0010, 0, 8);

        // 3: insufficient and reserved selection
        coins(2);
        finish(2'b10);
        chk_serv("t3a", 4'b0001, 2, 4);
        coins(4);
        finish(2'b11);
        chk_serv("t3b", 4'b0001, 4, 4);

        // 4: saturation and rejects
        for (int i = 1; i <= 17; i++) begin
            coin(r);
            chk($sformatf("t4.rechazo%0d", i), r, (i >= 16) ? 1 : 0);
        end
        chk("t4.monedas", MONEDAS, 15);
        chk("t4.rechazo_pulse", RECHAZO, 0);
        finish(2'b10);
        chk_serv("t4", 4'b0010, 6, 8);

        // 5: idle timeout, then a coin rejected during the warning
        coins(1);
        for (int i = 0; i < 30; i++) tick();
        chk("t5.pre_timeout", INSUFICIENTE, 0);
        tick();
        chk("t5.timeout", INSUFICIENTE, 1);
        chk("t5.vuelto", VUELTO, 1);
        coin(r);
        chk("t5.rechazo", r, 1);
        chk("t5.monedas", MONEDAS, 1);
        chk("t5.insuf3", INSUFICIENTE, 1);
        tick();
        chk("t5.insuf4", INSUFICIENTE, 1);
        tick();
        chk("t5.end", flags(), 0);
        chk("t5.end_monedas", MONEDAS, 0);

        // 6: coin and finish in the same cycle, then reset mid-service
        coins(2);
        SELECCION = 2'b00;
        INTRO_MONEDA = 1'b1;
        FINALIZAR_PAGO = 1'b1;
        tick();
        INTRO_MONEDA = 1'b0;
        FINALIZAR_PAGO = 1'b0;
        chk("t6.secado", flags(), 4'b1000);
        chk("t6.vuelto", VUELTO, 0);
        chk("t6.monedas", MONEDAS, 3);
        tick(); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t6.rst_flags", flags(), 0);
        chk("t6.rst_monedas", MONEDAS, 0);
        chk("t6.rst_misc", {RECHAZO, OCUPADO}, 0);
        tick();
        chk("t6.rst_stays", OCUPADO, 0);

        // 6b: finish held high for 10 cycles yields a single evaluation
        coins(3);
        SELECCION = 2'b00;
        FINALIZAR_PAGO = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (SECADO) hi++;
        end
        FINALIZAR_PAGO = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (SECADO) hi++;
        end
        chk("t6b.secado_cycles", hi, 8);
        chk("t6b.ocupado", OCUPADO, 0);
        chk("t6b.monedas", MONEDAS, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/controlador_lavadora_param.md
Name: controlador_lavadora_param

Overview:
Parametrised coin-operated laundry controller. It is the next-generation successor of the fixed 3/4/9-coin washer controller. It counts coin pulses and takes a service selection. On end-of-payment it starts the selected service and returns change, or flags an insufficient payment and refunds the coins. It returns to idle by itself, so no external RESET is needed between customers. It sits between the coin acceptor and button panel and the machine's actuator and display logic.

Parameters:
WIDTH, 5, bit width of the coin counter, VUELTO and MONEDAS.
PRECIO_SECADO, 3, coins required for a dry cycle.
PRECIO_LAVADO, 4, coins required for a wash cycle.
PRECIO_PESADO, 9, coins required for a heavy wash cycle.
MAX_MONEDAS, 15, counter saturation value. Must be ≤ 2^WIDTH-1 and ≥ every price.
DURACION, 8, clock cycles a service output stays asserted.
T_AVISO, 4, clock cycles INSUFICIENTE stays asserted.
T_ESPERA, 32, idle cycles in CONTANDO before an automatic timeout.

Ports:
clk  input  1  system clock; all logic on the rising edge.
RESET  input  1  synchronous reset, active-high.
INTRO_MONEDA  input  1  coin sensor level; each rising edge is one coin.
FINALIZAR_PAGO  input  1  end-payment button level; a rising edge triggers evaluation.
SELECCION  input  2  service choice: 00 secado, 01 lavado, 10 lavado pesado, 11 reserved.
SECADO  output  1  dry service active.
LAVADO  output  1  wash service active.
LAVADO_PESADO  output  1  heavy wash service active.
INSUFICIENTE  output  1  insufficient payment or timeout indication.
VUELTO  output  WIDTH  change or refund amount, valid while a service output or INSUFICIENTE is high; 0 otherwise.
MONEDAS  output  WIDTH  current coin count.
RECHAZO  output  1  one-cycle pulse when a coin is rejected.
OCUPADO  output  1  high in SERVICIO and INSUF.

Behaviour:
- Clock and reset: one clock, clk. RESET is synchronous and active-high.
- RESET values: state ESPERA, all outputs 0, internal counters 0, edge-detect registers 0. RESET has priority over every other event, including mid-service; outputs read 0 on the cycle after the RESET edge.
- Edge detection: each of INTRO_MONEDA and FINALIZAR_PAGO has a registered previous value. An edge is input=1 while the previous value=0. A level held high counts as one event only.
- Latency: a coin edge sampled at clock edge N makes MONEDAS +1 visible after edge N. A FINALIZAR_PAGO edge at N drives the service or INSUFICIENTE outputs high after edge N.
- ESPERA:
  - A coin edge loads MONEDAS with 1 and goes to CONTANDO.
  - A FINALIZAR_PAGO edge with 0 coins is ignored.
- CONTANDO:
  - A coin edge gives MONEDAS+1, saturating at MAX_MONEDAS.
  - A coin at saturation is not counted and pulses RECHAZO for one cycle.
  - Any coin edge clears the idle timer.
  - A FINALIZAR_PAGO edge evaluates the payment using the count including any coin arriving in the same cycle (count+1, saturated).
    - If SELECCION is not 11 and count ≥ price of the selected service: go to SERVICIO, latch the selected service, VUELTO = count − price.
    - Otherwise: go to INSUF, VUELTO = count (full refund).
  - With no coin edge for T_ESPERA consecutive cycles: go to INSUF with VUELTO = count.
- SERVICIO:
  - Exactly one of SECADO, LAVADO, LAVADO_PESADO is high for exactly DURACION cycles, with VUELTO held.
  - Then all outputs return to 0, MONEDAS = 0, state ESPERA.
- INSUF:
  - INSUFICIENTE is high for exactly T_AVISO cycles, with VUELTO held.
  - Then the same clearing as SERVICIO, state ESPERA.
- In SERVICIO and INSUF:
  - Coin edges pulse RECHAZO and are not counted.
  - FINALIZAR_PAGO edges are ignored.
  - SELECCION changes have no effect, because the service is latched.
- Mutual exclusion: SECADO, LAVADO, LAVADO_PESADO and INSUFICIENTE are never high together.
- Arithmetic: all counters are unsigned. The subtraction for VUELTO is performed only when count ≥ price, so it never underflows. The DURACION and T_AVISO cycle counters do not wrap.

Test Plan:
1. 3 coins, SELECCION=00, FINALIZAR_PAGO edge → SECADO=1 for 8 cycles, VUELTO=0; then MONEDAS=0, OCUPADO=0.
2. 5 coins, SELECCION=01, finish → LAVADO=1 for 8 cycles, VUELTO=1. Repeat with 9 coins and SELECCION=10 → LAVADO_PESADO=1, VUELTO=0.
3. 2 coins, SELECCION=10, finish → INSUFICIENTE=1 for 4 cycles, VUELTO=2. 4 coins, SELECCION=11 → INSUFICIENTE, VUELTO=4.
4. 17 coin edges in CONTANDO → MONEDAS saturates at 15, RECHAZO pulses on coins 16 and 17. SELECCION=10, finish → LAVADO_PESADO, VUELTO=6.
5. 1 coin then 32 idle cycles → INSUFICIENTE with VUELTO=1. A coin during the following INSUF window → RECHAZO=1, MONEDAS unchanged.
6. 2 coins, then 3rd coin edge and FINALIZAR_PAGO edge in the same cycle with SELECCION=00 → SECADO, VUELTO=0. RESET at service cycle 3 → all outputs 0 next cycle, state ESPERA. FINALIZAR_PAGO held high for 10 cycles → only one evaluation.
